// File: rtl/timer_seq_pkg.sv
// Shared types and constants for the timer sequencer: state encoding, default widths
// and the watchdog limit (2^W+1 COUNT cycles without RCO).
package timer_seq_pkg;

  localparam int W_DEF      = 4;
  localparam int REP_W_DEF  = 8;
  localparam int WDOG_LIMIT = (1 << W_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    TICK  = 2'd3
  } state_t;

  function automatic int wdog_limit(input int w);
    return (1 << w) + 1;
  endfunction

endpackage

// File: rtl/timer_seq_if.sv
// Control/status bundle between the sequencer (master) and a 161-type counter chain (slave).
// RCO is the ripple carry of the top stage; everything else is driven by the sequencer.
interface timer_seq_if
  import timer_seq_pkg::*;
#(
  parameter int W = W_DEF
);

  logic         LOAD_n;
  logic         ENP;
  logic         ENT;
  logic [W-1:0] D;
  logic         RCO;

  modport master (output LOAD_n, output ENP, output ENT, output D, input RCO);
  modport slave  (input LOAD_n, input ENP, input ENT, input D, output RCO);

endinterface

// File: rtl/timer_seq_wdog.sv
// Watchdog for a stuck RCO: counts consecutive COUNT cycles and flags the 2^W+1-th one
// if RCO is still low in it; the count clears whenever the FSM leaves COUNT.
module timer_seq_wdog
  import timer_seq_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic CLK,
  input  logic CLR,
  input  logic cnt_en,
  input  logic RCO,
  output logic expire
);

  localparam int         LIMIT = wdog_limit(W);
  localparam logic [W:0] LAST  = (W+1)'(LIMIT - 1);
  localparam logic [W:0] ONE   = (W+1)'(1);

  logic [W:0] wd_cnt;

  always_ff @(posedge CLK) begin
    if (CLR || !cnt_en) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + ONE;
    end
  end

  // wd_cnt holds the number of earlier COUNT cycles, so LAST marks the LIMIT-th one
  assign expire = cnt_en && !RCO && (wd_cnt == LAST);

endmodule

// File: rtl/timer_seq_ctrl.sv
// Interval timer sequencer around a loadable up-counter chain; one-shot or repeated intervals.
// Counter controls are registered from state (ENP also gated by RCO); TIMER_SEQ_WDOG_EN adds the stuck-RCO watchdog.
module timer_seq_ctrl
  import timer_seq_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic [W-1:0]     preset,
  timer_seq_if.master      cnt,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic             err
);

  state_t           state;
  logic [W-1:0]     preset_q;
  logic             periodic_q;
  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] intv_cnt;
  logic             load_n_q;
  logic             ent_q;
  logic             tick_q;
  logic             done_q;
  logic             busy_q;
  logic             last_intv;

  // intv_cnt counts completed intervals, so the one in progress is intv_cnt+1
  assign last_intv = !periodic_q || ((rep_q != '0) && ((intv_cnt + REP_W'(1)) == rep_q));

`ifdef TIMER_SEQ_WDOG_EN
  logic wdog_expire;
  logic err_q;

  timer_seq_wdog #(.W(W)) u_wdog (
    .CLK    (CLK),
    .CLR    (CLR),
    .cnt_en (state == COUNT),
    .RCO    (cnt.RCO),
    .expire (wdog_expire)
  );

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state      <= IDLE;
      preset_q   <= '0;
      periodic_q <= 1'b0;
      rep_q      <= '0;
      intv_cnt   <= '0;
      load_n_q   <= 1'b1;
      ent_q      <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef TIMER_SEQ_WDOG_EN
      err_q      <= 1'b0;
`endif
    end else begin
      load_n_q <= 1'b1;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            preset_q   <= preset;
            periodic_q <= periodic;
            rep_q      <= rep_cnt;
            intv_cnt   <= '0;
            load_n_q   <= 1'b0;
            busy_q     <= 1'b1;
            state      <= LOAD;
`ifdef TIMER_SEQ_WDOG_EN
            err_q      <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (stop) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            ent_q <= 1'b1;
            state <= COUNT;
          end
        end
        COUNT: begin
          // stop outranks a coincident RCO: the interval is abandoned, not reported
          if (stop) begin
            ent_q  <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (cnt.RCO) begin
            ent_q  <= 1'b0;
            tick_q <= 1'b1;
            done_q <= last_intv;
            state  <= TICK;
          end
`ifdef TIMER_SEQ_WDOG_EN
          else if (wdog_expire) begin
            ent_q  <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b1;
            state  <= IDLE;
          end
`endif
        end
        TICK: begin
          intv_cnt <= intv_cnt + REP_W'(1);
          if (stop || last_intv) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            load_n_q <= 1'b0;
            state    <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cnt.LOAD_n = load_n_q;
  assign cnt.ENT    = ent_q;
  assign cnt.ENP    = ent_q & ~cnt.RCO;
  assign cnt.D      = preset_q;
  assign tick       = tick_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Bench for timer_seq_ctrl with W=4 driving a 161-type counter model; vector table plus
// hand-written sequences for reset, stop/RCO collision, start-while-busy, watchdog and CLR.
module tb_timer_seq_ctrl;
  import timer_seq_pkg::*;

  localparam int W     = 4;
  localparam int REP_W = 8;

  logic             CLK      = 1'b0;
  logic             CLR      = 1'b1;
  logic             start    = 1'b0;
  logic             stop     = 1'b0;
  logic             periodic = 1'b0;
  logic [REP_W-1:0] rep_cnt  = '0;
  logic [W-1:0]     preset   = '0;
  logic             tick, done, busy, err;
  logic             rco_kill = 1'b0;
  logic [W-1:0]     q;

  int checks = 0;
  int errors = 0;

  timer_seq_if #(.W(W)) cif ();

  timer_seq_ctrl #(.W(W), .REP_W(REP_W)) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .rep_cnt  (rep_cnt),
    .preset   (preset),
    .cnt      (cif),
    .tick     (tick),
    .done     (done),
    .busy     (busy),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  // 161-type chain: synchronous load, counts only with ENP&ENT, RCO gated by ENT
  always_ff @(posedge CLK) begin
    if (!cif.LOAD_n)              q <= cif.D;
    else if (cif.ENP && cif.ENT)  q <= q + 4'd1;
  end
  assign cif.RCO = !rco_kill && cif.ENT && (q == 4'hF);

  typedef struct {
    logic [W-1:0]     p;
    logic             per;
    logic [REP_W-1:0] rep;
    int               stop_at;
    int               ncyc;
    int               first_tick;
    int               n_tick;
    int               last_tick;
    int               done_at;
    int               last_busy;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start_run(input logic [W-1:0] p, input logic per, input logic [REP_W-1:0] rep);
    @(negedge CLK);
    preset   = p;
    periodic = per;
    rep_cnt  = rep;
    start    = 1'b1;
    @(posedge CLK);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int ft, nt, lt, dt, nd, lb, wrap;
    logic [W-1:0] pq;
    logic pent;
    ft = 0; nt = 0; lt = 0; dt = 0; nd = 0; lb = 0; wrap = 0; pq = '0; pent = 1'b0;
    start_run(v.p, v.per, v.rep);
    for (int c = 1; c <= v.ncyc; c++) begin
      @(negedge CLK);
      start = 1'b0;
      if (tick) begin
        if (ft == 0) ft = c;
        lt = c;
        nt++;
      end
      if (done) begin
        if (dt == 0) dt = c;
        nd++;
      end
      if (busy) lb = c;
      if (pent && pq == 4'hF && q == 4'h0) wrap = 1;
      pq   = q;
      pent = cif.ENT;
      stop = (c == v.stop_at);
    end
    stop = 1'b0;
    check($sformatf("v%0d_first_tick", idx), ft, v.first_tick);
    check($sformatf("v%0d_n_tick", idx), nt, v.n_tick);
    check($sformatf("v%0d_last_tick", idx), lt, v.last_tick);
    check($sformatf("v%0d_done_at", idx), dt, v.done_at);
    check($sformatf("v%0d_n_done", idx), nd, (v.done_at != 0) ? 1 : 0);
    check($sformatf("v%0d_last_busy", idx), lb, v.last_busy);
    check($sformatf("v%0d_wrap", idx), wrap, 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_LOAD_n"}, int'(cif.LOAD_n), 1);
    check({tag, "_ENP"}, int'(cif.ENP), 0);
    check({tag, "_ENT"}, int'(cif.ENT), 0);
    check({tag, "_D"}, int'(cif.D), 0);
    check({tag, "_tick"}, int'(tick), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  initial begin
    int nt;
    //        p     per   rep    stop ncyc ft nt lt  done lb
    vecs[0] = '{4'd12, 1'b0, 8'd0, 0,  10,  6, 1, 6,  6,  6};
    vecs[1] = '{4'd14, 1'b1, 8'd3, 0,  16,  4, 3, 12, 12, 12};
    vecs[2] = '{4'd15, 1'b0, 8'd0, 0,  6,   3, 1, 3,  3,  3};
    vecs[3] = '{4'd0,  1'b0, 8'd0, 0,  22, 18, 1, 18, 18, 18};
    vecs[4] = '{4'd14, 1'b1, 8'd0, 14, 20,  4, 3, 12, 0,  14};
    vecs[5] = '{4'd14, 1'b0, 8'd0, 3,  6,   0, 0, 0,  0,  3};
    vecs[6] = '{4'd13, 1'b1, 8'd2, 0,  14,  5, 2, 10, 10, 10};
    vecs[7] = '{4'd15, 1'b1, 8'd1, 0,  6,   3, 1, 3,  3,  3};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_outs("reset");
    CLR = 1'b0;

    // one-shot detail: LOAD, Q stepping 12..15, RCO gating ENP, tick/done, busy release
    start_run(4'd12, 1'b0, 8'd0);
    @(negedge CLK); start = 1'b0;
    check("os_c1_LOAD_n", int'(cif.LOAD_n), 0);
    check("os_c1_D", int'(cif.D), 12);
    check("os_c1_busy", int'(busy), 1);
    for (int c = 2; c <= 5; c++) begin
      @(negedge CLK);
      check($sformatf("os_c%0d_Q", c), int'(q), 10 + c);
      check($sformatf("os_c%0d_ENT", c), int'(cif.ENT), 1);
    end
    check("os_c5_ENP", int'(cif.ENP), 0);
    @(negedge CLK);
    check("os_c6_tick", int'(tick), 1);
    check("os_c6_done", int'(done), 1);
    @(negedge CLK);
    check("os_c7_busy", int'(busy), 0);
    check("os_c7_LOAD_n", int'(cif.LOAD_n), 1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // start while busy is ignored; a start in the cycle after done is accepted
    start_run(4'd14, 1'b0, 8'd0);
    @(negedge CLK); start = 1'b0;
    @(negedge CLK); start = 1'b1; preset = 4'd3;
    @(negedge CLK); start = 1'b0;
    check("bsy_D_kept", int'(cif.D), 14);
    @(negedge CLK);
    check("bsy_tick_c4", int'(tick), 1);
    check("bsy_done_c4", int'(done), 1);
    @(negedge CLK);
    check("b2b_c5_busy", int'(busy), 0);
    start = 1'b1; preset = 4'd15;
    @(negedge CLK); start = 1'b0;
    check("b2b_c6_LOAD_n", int'(cif.LOAD_n), 0);
    check("b2b_c6_D", int'(cif.D), 15);
    repeat (4) @(negedge CLK);
    check("b2b_end_busy", int'(busy), 0);

    // stuck RCO
    rco_kill = 1'b1;
    nt = 0;
    start_run(4'd0, 1'b0, 8'd0);
    for (int c = 1; c <= 19; c++) begin
      @(negedge CLK);
      start = 1'b0;
      if (tick) nt++;
      if (c == 18) check("wd_c18_busy", int'(busy), 1);
    end
    check("wd_no_tick", nt, 0);
`ifdef TIMER_SEQ_WDOG_EN
    check("wd_err_set", int'(err), 1);
    check("wd_idle", int'(busy), 0);
    start = 1'b1;
    @(negedge CLK); start = 1'b0;
    check("wd_err_cleared", int'(err), 0);
    check("wd_restart_busy", int'(busy), 1);
`else
    check("wd_off_err", int'(err), 0);
    check("wd_off_busy", int'(busy), 1);
    repeat (11) @(negedge CLK);
    check("wd_off_err_late", int'(err), 0);
    check("wd_off_busy_late", int'(busy), 1);
`endif
    stop = 1'b1;
    @(negedge CLK); stop = 1'b0;
    check("wd_stop_busy", int'(busy), 0);
    check("wd_stop_done", int'(done), 0);
    rco_kill = 1'b0;

    // CLR mid-COUNT
    start_run(4'd0, 1'b1, 8'd0);
    repeat (5) @(negedge CLK);
    start = 1'b0;
    check("clr_pre_ENT", int'(cif.ENT), 1);
    CLR = 1'b1;
    @(negedge CLK);
    check_reset_outs("clr");
    CLR = 1'b0;
    @(negedge CLK);
    check("clr_after_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_seq_ctrl.md
# timer_seq_ctrl

Sequencer for a W-bit synchronous loadable up-counter (cascaded 4-bit 161-type stages, RCO from the top stage). Drives the counter's LOAD_n/ENP/ENT/D, watches its RCO, and turns it into a programmable interval timer. Supports one-shot or repeated intervals with a repeat count, abort, and an optional watchdog. Sits between the system control logic and the counter chain in the timer datapath.

## Interface
- W, 4: counter width, multiple of 4.
- REP_W, 8: repeat-count width.
- CLK  in  1  clock; all logic rising-edge.
- CLR  in  1  reset, synchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- stop  in  1  abort the run; highest priority after CLR.
- periodic  in  1  0 = one interval, 1 = repeat; captured at start.
- rep_cnt  in  REP_W  intervals to run when periodic; 0 = run until stop; captured at start.
- preset  in  W  counter load value; captured at start.
- RCO  in  1  ripple carry from the counter chain.
- LOAD_n  out  1  counter parallel-load, active-low.
- ENP  out  1  counter count-enable parallel.
- ENT  out  1  counter count-enable trickle.
- D  out  W  counter load data.
- tick  out  1  one-cycle pulse per completed interval.
- done  out  1  one-cycle pulse at the end of the run.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky watchdog error; cleared by CLR or an accepted start.

## Operation
- States: IDLE, LOAD, COUNT, TICK.
- IDLE: start=1 captures preset, periodic and rep_cnt, clears the interval counter, and moves to LOAD.
- LOAD: LOAD_n=0, D=captured preset; next state COUNT.
- COUNT: ENT=1, ENP=~RCO. The counter holds at all-ones when terminal count is reached, with no wrap. RCO=1 moves to TICK.
- TICK: tick=1 and the interval counter increments. Next state is IDLE with done=1 in the same TICK cycle when either:
  - periodic=0, or
  - rep_cnt≠0 and this is interval number rep_cnt.
  Otherwise the next state is LOAD.
- stop=1 in any non-IDLE state: next state IDLE, with no tick and no done in that cycle. stop wins over a simultaneous RCO.
- start while busy is ignored; captured values never change mid-run.
- Interval counter is REP_W bits. In continuous mode (rep_cnt=0) it wraps silently.
- LOAD_n, ENP, ENT, tick, done and busy are decoded from state and RCO only (Moore plus the ENP gating). No combinational path runs from start/stop to the counter controls.
- Reset: state IDLE, LOAD_n=1, ENP=0, ENT=0, D=0, tick=0, done=0, busy=0, err=0, captured registers 0. CLR mid-run aborts immediately, with no done.

## Timing
- start sampled at edge 0. Cycle 1 is LOAD. COUNT lasts 2^W−P cycles. TICK comes next.
- First tick is in cycle 2^W−P+2 after the start edge.
- Periodic period is 2^W−P+2 cycles: LOAD + COUNT + TICK.
- P=2^W−1 gives COUNT of 1 cycle and period 3. P=0 gives period 2^W+2.
- A new start is accepted in the cycle after done, since IDLE is re-entered then.

## Configuration
- TIMER_SEQ_WDOG_EN defined:
  - A (W+1)-bit counter counts COUNT cycles.
  - If it reaches 2^W+1 with no RCO, err is set and the next state is IDLE, with no tick and no done.
- TIMER_SEQ_WDOG_EN undefined:
  - No watchdog logic; err is tied 0.
  - A stuck-low RCO leaves the block in COUNT until stop or CLR.

## Structure
- Package timer_seq_pkg holds:
  - the state enum (IDLE/LOAD/COUNT/TICK);
  - defaults for W and REP_W;
  - the localparam for the watchdog limit, 2^W+1.
- Sub-module timer_seq_wdog holds the watchdog counter and compare. It is instantiated only under TIMER_SEQ_WDOG_EN.
- The FSM and capture registers stay in the top level.

## Test plan
Bench uses W=4 with a real 161-type counter model.
- One-shot: preset=12, periodic=0, start. → LOAD at cycle 1; Q=12,13,14,15 over cycles 2–5; tick and done in cycle 6; busy low from cycle 7.
- Periodic: preset=14, periodic=1, rep_cnt=3. → ticks at cycles 4, 8 and 12; done only at cycle 12; Q never wraps to 0 while ENT=1.
- Boundaries: preset=15 → tick at cycle 3. preset=0 → tick at cycle 18. rep_cnt=0 with periodic=1 → ticks every 4 cycles (preset 14) until stop, then IDLE with no done.
- Stop/RCO collision: stop asserted in the COUNT cycle where RCO=1. → no tick, no done, IDLE next cycle. A start during busy is ignored.
- Watchdog (macro on): RCO forced 0. → err set after 17 COUNT cycles, IDLE, no tick. A new start clears err. With the macro off, err stays 0 and busy stays 1.
- CLR mid-COUNT: all outputs return to their reset values the next cycle, and LOAD_n=1.
